imem_responder: RTL and testbench
=================================

// Module: imem_responder
// PURPOSE
//  Responder end of the fetch <-> instruction-memory interface: serves the
//  word-aligned instruction address issued by fetch and returns the instruction
//  after a fixed, parameterised latency. Also accepts program-load writes on the
//  same port. !enable (fetch stall) freezes the whole read pipeline. Out-of-range
//  or misaligned accesses are flagged and return a NOP.
// PARAMETERS
//  BASE_ADDR  32'h01000000  byte address of word 0 (fetch reset PC)
//  DEPTH      1024          number of 32-bit words; power of two
//  LATENCY    1             read latency in cycles, 1..4
//  INIT_FILE  ""            $readmemh image loaded at elaboration; "" = no preload
// PORTS
//  clock       in   1   single clock, all state on posedge
//  reset       in   1   synchronous, active-high
//  enable      in   1   1 = accept request and advance pipeline; 0 = hold everything
//  read_write  in   1   0 = read, 1 = write
//  address     in   32  byte address
//  data_in     in   32  write data (full word)
//  data_out    out  32  instruction for the request issued LATENCY cycles earlier
//  resp_addr   out  32  address belonging to data_out
//  resp_valid  out  1   data_out/resp_addr hold a completed read response
//  fault       out  1   response is for an out-of-range or misaligned address
// BEHAVIOUR
//  - Reset: data_out=32'h00000013 (NOP), resp_addr=BASE_ADDR, resp_valid=0,
//    fault=0, every pipeline stage invalid. Memory contents are not cleared.
//  - Index: idx = (address - BASE_ADDR) >> 2, computed in 32 bits (wraps
//    modulo 2^32). In range iff address >= BASE_ADDR and idx < DEPTH.
//    Misaligned iff address[1:0] != 0.
//  - Read (enable=1, read_write=0): stage 1 captures {valid=1, addr,
//    mem[idx] or NOP, fault}. Each stage shifts one step per enabled cycle.
//    Outputs equal the last stage, so the response appears LATENCY enabled
//    cycles after the request. fault=1 forces data=NOP.
//  - Write (enable=1, read_write=1): if in range and aligned, mem[idx]<=data_in
//    on this edge. A bad write is dropped with no memory change. Stage 1 captures
//    an invalid bubble with fault = bad-write flag, so a bad write is reported on
//    fault with resp_valid=0.
//  - Read-after-write to the same index on the next enabled cycle returns the new
//    data. No same-cycle bypass is needed, because reads and writes share one port.
//  - enable=0: no memory access and no pipeline shift. All outputs hold their
//    values bit-for-bit (fetch stall).
//  - reset has priority over enable. Reset mid-pipeline discards in-flight
//    responses. A write presented on the reset cycle is not performed.
//  - LATENCY is checked at elaboration: outside 1..4 is a fatal error.
//  - X on address while enable=0 must not propagate to the outputs.
// STRUCTURE
//  - Shared package rv_mem_pkg: RV_NOP=32'h00000013, RESET_PC=32'h01000000,
//    resp_stage_t struct {valid, fault, addr[31:0], data[31:0]}.
//  - One sub-module, imem_resp_pipe: a LATENCY-deep shift register of
//    resp_stage_t with a common advance (enable) and synchronous clear (reset).
//    The top level holds the array, address decode and write path.
// TESTING
//  1 Reset, then LATENCY=1, preload word0=0x00500093: read 0x01000000 ->
//    next cycle data_out=0x00500093, resp_addr=0x01000000, resp_valid=1.
//  2 Write 0xDEADBEEF to 0x01000008, read 0x01000008 on the next cycle ->
//    data_out=0xDEADBEEF.
//  3 LATENCY=3, back-to-back reads 0x01000000/04/08 with enable low for 2 cycles
//    mid-stream -> responses in order, outputs frozen during the low cycles,
//    each response 3 enabled cycles after its request.
//  4 Read 0x00FFFFFC, then 0x01001000 (DEPTH=1024), then 0x01000002 ->
//    fault=1, data_out=0x00000013, resp_valid=1 each time.
//  5 Write to 0x01001000 -> memory unchanged (read back old word), fault=1 with
//    resp_valid=0 on the response slot.
//  6 Assert reset with 2 reads in flight (LATENCY=3) -> resp_valid=0 from the
//    next edge, and no stale response ever appears. Memory still holds the
//    earlier writes.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared definitions for the fetch <-> instruction-memory interface.
package rv_mem_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] RV_NOP   = 32'h00000013;
  localparam logic [31:0] RESET_PC = 32'h01000000;

  // One slot of the read-response pipeline.
  typedef struct packed {
    logic        valid;
    logic        fault;
    logic [31:0] addr;
    logic [31:0] data;
  } resp_stage_t;

  // Instruction fetches must be word aligned.
  function automatic logic addr_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/imem_resp_pipe.sv
// LATENCY-deep response shift register with a common advance and synchronous clear.
module imem_resp_pipe
  import rv_mem_pkg::*;
#(
  parameter int unsigned LATENCY    = 1,
  parameter logic [31:0] RESET_ADDR = RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        advance,
  input  resp_stage_t stage_in,
  output resp_stage_t stage_out
);

  localparam resp_stage_t ResetStage = '{
    valid: 1'b0,
    fault: 1'b0,
    addr:  RESET_ADDR,
    data:  RV_NOP
  };

  resp_stage_t stage_q [LATENCY];

  // Clear every slot on reset; otherwise shift one step per enabled cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        stage_q[i] <= ResetStage;
      end
    end else if (advance) begin
      stage_q[0] <= stage_in;
      for (int i = 1; i < int'(LATENCY); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign stage_out = stage_q[LATENCY-1];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: single read/write port, fixed read latency,
// stall on !enable, faults on out-of-range or misaligned accesses.
module imem_responder
  import rv_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = RESET_PC,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter string       INIT_FILE = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        read_write,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [31:0] resp_addr,
  output logic        resp_valid,
  output logic        fault
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $fatal(1, "imem_responder: LATENCY must be in 1..4");
  end

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "imem_responder: DEPTH must be a power of two >= 2");
  end

  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     word_off;
  logic [IdxW-1:0] idx;
  logic            in_range;
  logic            bad;
  logic            do_write;
  logic [31:0]     rd_word;
  resp_stage_t     stage_in;
  resp_stage_t     stage_out;

  // Offset wraps modulo 2^32, so addresses below BASE_ADDR need the explicit compare.
  assign word_off = (address - BASE_ADDR) >> 2;
  assign idx      = word_off[IdxW-1:0];
  assign in_range = (address >= BASE_ADDR) && (word_off < DEPTH);
  assign bad      = !in_range || addr_misaligned(address);
  assign do_write = !reset && enable && read_write && !bad;
  assign rd_word  = mem_q[idx];

  // Program-load write path; memory is never cleared by reset.
  always_ff @(posedge clock) begin
    if (do_write) begin
      mem_q[idx] <= data_in;
    end
  end

  // Build the stage-1 entry: reads carry data, writes become bubbles carrying the bad flag.
  always_comb begin
    stage_in.valid = !read_write;
    stage_in.fault = bad;
    stage_in.addr  = address;
    stage_in.data  = RV_NOP;
    if (!read_write && !bad) begin
      stage_in.data = rd_word;
    end
  end

  imem_resp_pipe #(
    .LATENCY    (LATENCY),
    .RESET_ADDR (BASE_ADDR)
  ) u_resp_pipe (
    .clock     (clock),
    .reset     (reset),
    .advance   (enable),
    .stage_in  (stage_in),
    .stage_out (stage_out)
  );

  assign data_out   = stage_out.data;
  assign resp_addr  = stage_out.addr;
  assign resp_valid = stage_out.valid;
  assign fault      = stage_out.fault;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder at LATENCY=1 and LATENCY=3.
module tb_imem_responder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // LATENCY=1 instance
  logic        rst1 = 1'b1, en1 = 1'b0, rw1 = 1'b0;
  logic [31:0] addr1 = 32'h0, din1 = 32'h0;
  logic [31:0] dout1, raddr1;
  logic        rv1, flt1;

  // LATENCY=3 instance
  logic        rst3 = 1'b1, en3 = 1'b0, rw3 = 1'b0;
  logic [31:0] addr3 = 32'h0, din3 = 32'h0;
  logic [31:0] dout3, raddr3;
  logic        rv3, flt3;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  localparam logic [31:0] Nop  = 32'h00000013;
  localparam logic [31:0] Base = 32'h01000000;
  localparam logic [31:0] A0   = 32'h00100093;
  localparam logic [31:0] A1   = 32'h00200113;
  localparam logic [31:0] A2   = 32'h00300193;

  imem_responder #(
    .LATENCY (1)
  ) u_dut1 (
    .clock      (clock),
    .reset      (rst1),
    .enable     (en1),
    .read_write (rw1),
    .address    (addr1),
    .data_in    (din1),
    .data_out   (dout1),
    .resp_addr  (raddr1),
    .resp_valid (rv1),
    .fault      (flt1)
  );

  imem_responder #(
    .LATENCY (3)
  ) u_dut3 (
    .clock      (clock),
    .reset      (rst3),
    .enable     (en3),
    .read_write (rw3),
    .address    (addr3),
    .data_in    (din3),
    .data_out   (dout3),
    .resp_addr  (raddr3),
    .resp_valid (rv3),
    .fault      (flt3)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive1(input logic en, input logic rw, input logic [31:0] a, input logic [31:0] d);
    en1 = en; rw1 = rw; addr1 = a; din1 = d;
  endtask

  task automatic drive3(input logic en, input logic rw, input logic [31:0] a, input logic [31:0] d);
    en3 = en; rw3 = rw; addr3 = a; din3 = d;
  endtask

  task automatic check1(input string tag, input logic [31:0] d, input logic [31:0] a,
                        input logic v, input logic f);
    check_val({tag, ".data"}, dout1, d);
    check_val({tag, ".addr"}, raddr1, a);
    check_val({tag, ".valid"}, {31'b0, rv1}, {31'b0, v});
    check_val({tag, ".fault"}, {31'b0, flt1}, {31'b0, f});
  endtask

  task automatic check3(input string tag, input logic [31:0] d, input logic [31:0] a,
                        input logic v, input logic f);
    check_val({tag, ".data"}, dout3, d);
    check_val({tag, ".addr"}, raddr3, a);
    check_val({tag, ".valid"}, {31'b0, rv3}, {31'b0, v});
    check_val({tag, ".fault"}, {31'b0, flt3}, {31'b0, f});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset both instances.
    drive1(1'b1, 1'b1, Base, 32'hFFFFFFFF);  // write during reset must be ignored
    tick(); tick();
    check1("rst1", Nop, Base, 1'b0, 1'b0);
    check3("rst3", Nop, Base, 1'b0, 1'b0);
    rst1 = 1'b0; rst3 = 1'b0;

    // ---- LATENCY=1 ----
    drive1(1'b1, 1'b1, Base, 32'h00500093);
    tick();
    check1("wr_bubble", Nop, Base, 1'b0, 1'b0);
    drive1(1'b1, 1'b0, Base, 32'h0);
    tick();
    check1("rd_word0", 32'h00500093, Base, 1'b1, 1'b0);

    drive1(1'b1, 1'b1, 32'h01000008, 32'hDEADBEEF);
    tick();
    drive1(1'b1, 1'b0, 32'h01000008, 32'h0);
    tick();
    check1("raw", 32'hDEADBEEF, 32'h01000008, 1'b1, 1'b0);

    // Stall: outputs hold while inputs wander.
    drive1(1'b0, 1'b1, 32'h01000008, 32'h55555555);
    tick();
    check1("stall1", 32'hDEADBEEF, 32'h01000008, 1'b1, 1'b0);
    drive1(1'b1, 1'b0, 32'h01000008, 32'h0);
    tick();
    check_val("stall_nowrite", dout1, 32'hDEADBEEF);

    // Faulting reads.
    drive1(1'b1, 1'b0, 32'h00FFFFFC, 32'h0);
    tick();
    check1("below_base", Nop, 32'h00FFFFFC, 1'b1, 1'b1);
    drive1(1'b1, 1'b0, 32'h01001000, 32'h0);
    tick();
    check1("past_end", Nop, 32'h01001000, 1'b1, 1'b1);
    drive1(1'b1, 1'b0, 32'h01000002, 32'h0);
    tick();
    check1("misalign", Nop, 32'h01000002, 1'b1, 1'b1);

    // Bad writes are dropped and flagged with resp_valid=0.
    drive1(1'b1, 1'b1, 32'h01001000, 32'h12345678);
    tick();
    check1("bad_wr", Nop, 32'h01001000, 1'b0, 1'b1);
    drive1(1'b1, 1'b0, Base, 32'h0);
    tick();
    check1("bad_wr_rb", 32'h00500093, Base, 1'b1, 1'b0);
    drive1(1'b1, 1'b1, 32'h01000004, 32'h11111111);
    tick();
    drive1(1'b1, 1'b1, 32'h01000006, 32'h22222222);
    tick();
    check1("mis_wr", Nop, 32'h01000006, 1'b0, 1'b1);
    drive1(1'b1, 1'b0, 32'h01000004, 32'h0);
    tick();
    check1("mis_wr_rb", 32'h11111111, 32'h01000004, 1'b1, 1'b0);

    // ---- LATENCY=3 ----
    drive3(1'b1, 1'b1, Base, A0);          tick();
    drive3(1'b1, 1'b1, 32'h01000004, A1);  tick();
    drive3(1'b1, 1'b1, 32'h01000008, A2);  tick();
    drive3(1'b1, 1'b0, Base, 32'h0);       tick();
    drive3(1'b1, 1'b0, 32'h01000004, 32'h0); tick();
    check_val("l3_not_early", {31'b0, rv3}, 32'h0);
    drive3(1'b1, 1'b0, 32'h01000008, 32'h0); tick();
    check3("l3_r0", A0, Base, 1'b1, 1'b0);
    // Two stalled cycles with a would-be write to word 0.
    drive3(1'b0, 1'b1, Base, 32'hFFFFFFFF); tick();
    check3("l3_hold1", A0, Base, 1'b1, 1'b0);
    drive3(1'b0, 1'b0, 32'h01000FFC, 32'h0); tick();
    check3("l3_hold2", A0, Base, 1'b1, 1'b0);
    drive3(1'b1, 1'b0, 32'h01000004, 32'h0); tick();
    check3("l3_r1", A1, 32'h01000004, 1'b1, 1'b0);
    drive3(1'b1, 1'b0, Base, 32'h0);       tick();
    check3("l3_r2", A2, 32'h01000008, 1'b1, 1'b0);

    // Reset with two reads in flight, plus a write on the reset cycle.
    rst3 = 1'b1;
    drive3(1'b1, 1'b1, 32'h01000008, 32'hBADBAD00);
    tick();
    check3("l3_rst", Nop, Base, 1'b0, 1'b0);
    rst3 = 1'b0;
    drive3(1'b1, 1'b0, 32'h01000008, 32'h0); tick();
    check_val("l3_nostale1", {31'b0, rv3}, 32'h0);
    drive3(1'b1, 1'b0, Base, 32'h0);       tick();
    check_val("l3_nostale2", {31'b0, rv3}, 32'h0);
    drive3(1'b1, 1'b0, 32'h01000004, 32'h0); tick();
    check3("l3_keep08", A2, 32'h01000008, 1'b1, 1'b0);
    drive3(1'b1, 1'b0, 32'h01000004, 32'h0); tick();
    check3("l3_keep00", A0, Base, 1'b1, 1'b0);
    drive3(1'b1, 1'b0, 32'h01000004, 32'h0); tick();
    check3("l3_keep04", A1, 32'h01000004, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
